// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants and shared display types.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned FC_W  = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // ppu transparent colour, used by the sprite display modules
  localparam rgb_t NO_PIXEL = rgb_t'(24'h202020);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  // Raw sync/active decode for one count pair (syncs active-low).
  function automatic ctl_t decode_ctl(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    ctl_t c;
    c.hs  = !((h >= CNT_W'(HS_START)) && (h < CNT_W'(HS_END)));
    c.vs  = !((v >= CNT_W'(VS_START)) && (v < CNT_W'(VS_END)));
    c.act = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    return c;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Raster counts, composited pixel return and VGA DAC pins of the display back end.
interface vga_scanout_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             vblank;
  logic             frame_start;
  logic [FC_W-1:0]  frame_count;
  rgb_t             RGB_input;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_BLANK_n;
  logic             VGA_SYNC_n;
  logic             VGA_CLK;

  modport master (
    output hcount, vcount, vblank, frame_start, frame_count,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK,
    input  RGB_input
  );

  modport slave (
    input  hcount, vcount, vblank, frame_start, frame_count,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK,
    output RGB_input
  );

endinterface

// File: rtl/vga_counters.sv
// Pixel-tick divider, raster h/v counters and frame-start / frame counter.
module vga_counters
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             tick_c,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             frame_start_q, frame_start_d;
  logic [FC_W-1:0]  frame_count_q, frame_count_d;

  // Advance counts on pixel ticks only; pulse frame_start on the wrap to (0,0).
  always_comb begin
    pix_en_d      = ~pix_en_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (pix_en_q) begin
      if (hcount_q == CNT_W'(H_TOTAL - 1)) begin
        hcount_d = '0;
        if (vcount_q == CNT_W'(V_TOTAL - 1)) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + FC_W'(1);
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tick_c      = pix_en_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA back end: raster counters, sync decode aligned to the pixel pipeline, DAC output register.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIPE_DLY  = 1,
  parameter rgb_t        BLANK_RGB = rgb_t'(24'h000000)
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  localparam int LINE_N = int'(PIPE_DLY) - 1;

  logic             tick;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  ctl_t             ctl_raw;
  ctl_t             ctl_tail;

  vga_counters u_cnt (
    .clk         (clk),
    .reset       (reset),
    .tick_c      (tick),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (bus.frame_start),
    .frame_count (bus.frame_count)
  );

  assign ctl_raw = decode_ctl(hcount, vcount);

  // Delay the control bits by the upstream pixel latency so they meet RGB_input.
  generate
    if (LINE_N > 0) begin : g_line
      ctl_t line_q [LINE_N];
      ctl_t line_d [LINE_N];

      always_comb begin
        line_d = line_q;
        if (tick) begin
          line_d[0] = ctl_raw;
          for (int i = 1; i < LINE_N; i++) begin
            line_d[i] = line_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LINE_N; i++) begin
            line_q[i] <= CTL_IDLE;
          end
        end else begin
          line_q <= line_d;
        end
      end

      assign ctl_tail = line_q[LINE_N-1];
    end else begin : g_direct
      assign ctl_tail = ctl_raw;
    end
  endgenerate

  rgb_t rgb_q, rgb_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic blank_n_q, blank_n_d;

  // Output register: loads pixel and aligned controls together on each tick.
  always_comb begin
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (tick) begin
      rgb_d     = ctl_tail.act ? bus.RGB_input : BLANK_RGB;
      hs_d      = ctl_tail.hs;
      vs_d      = ctl_tail.vs;
      blank_n_d = ctl_tail.act;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign bus.hcount      = hcount;
  assign bus.vcount      = vcount;
  assign bus.vblank      = (vcount >= CNT_W'(V_ACTIVE));
  assign bus.VGA_R       = rgb_q.r;
  assign bus.VGA_G       = rgb_q.g;
  assign bus.VGA_B       = rgb_q.b;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_n = blank_n_q;
  assign bus.VGA_SYNC_n  = 1'b0;
  // DAC latches on the rising edge of pix_en, mid-pixel after the outputs settle.
  assign bus.VGA_CLK     = tick;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboarded bench for vga_scanout: PIPE_DLY=1 with combinational upstream, PIPE_DLY=3 with a 2-tick upstream.
module tb_vga_scanout;
  import vga_timing_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_scanout_if if1 ();
  vga_scanout_if if3 ();

  vga_scanout #(.PIPE_DLY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  vga_scanout #(.PIPE_DLY(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  function automatic logic [23:0] pix(input logic [9:0] h, input logic [9:0] v);
    return {h[7:0], v[7:0], 8'hA5};
  endfunction

  // Expected {rgb, hs, vs, blank_n} for the pins showing count pair (h,v).
  function automatic logic [26:0] pins(input logic [9:0] h, input logic [9:0] v);
    logic act;
    act = (h < 10'd640) && (v < 10'd480);
    return {act ? pix(h, v) : 24'h000000,
            !((h >= 10'd656) && (h < 10'd752)),
            !((v >= 10'd490) && (v < 10'd492)),
            act};
  endfunction

  // Upstream stand-ins: combinational for dut1, two ticks of latency for dut3.
  assign if1.RGB_input = pix(if1.hcount, if1.vcount);
  logic [23:0] up1, up2;
  always @(posedge clk) begin
    if (!reset) begin
      up1 <= 24'h0;
      up2 <= 24'h0;
    end else if (if3.VGA_CLK) begin
      up1 <= pix(if3.hcount, if3.vcount);
      up2 <= up1;
    end
  end
  assign if3.RGB_input = up2;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        vb;
    logic        fs;
    logic [15:0] fc;
    logic        ck;
    logic [23:0] rgb1;
    logic        hs1, vs1, bn1;
    logic [23:0] rgb3;
    logic        hs3, vs3, bn3;
  } obs_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Counter jumps requested by the stimulus; the model adopts them on the next edge.
  int          jump_seq  = 0;
  int          jump_seen = 0;
  logic [9:0]  jh, jv;
  logic [15:0] jfc;

  logic [9:0]  mh, mv, h1, v1, h2, v2;
  logic [15:0] mfc;
  logic        mp, ok1, ok2;
  obs_t        e;

  // Reference model: predicts the post-edge outputs of every clock and queues them.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      mp = 1'b0; mh = '0; mv = '0; mfc = '0; ok1 = 1'b0; ok2 = 1'b0;
      jump_seen = jump_seq;
      e.fs = 1'b0;
      {e.rgb1, e.hs1, e.vs1, e.bn1} = {24'h0, 1'b1, 1'b1, 1'b0};
      {e.rgb3, e.hs3, e.vs3, e.bn3} = {24'h0, 1'b1, 1'b1, 1'b0};
    end else begin
      if (jump_seen != jump_seq) begin
        mh = jh; mv = jv; mfc = jfc;
        jump_seen = jump_seq;
      end
      e.fs = 1'b0;
      if (mp) begin
        {e.rgb1, e.hs1, e.vs1, e.bn1} = pins(mh, mv);
        if (ok2) {e.rgb3, e.hs3, e.vs3, e.bn3} = pins(h2, v2);
        else     {e.rgb3, e.hs3, e.vs3, e.bn3} = {24'h0, 1'b1, 1'b1, 1'b0};
        h2 = h1; v2 = v1; ok2 = ok1;
        h1 = mh; v1 = mv; ok1 = 1'b1;
        if (mh == 10'd799) begin
          mh = '0;
          if (mv == 10'd524) begin
            mv = '0;
            e.fs = 1'b1;
            mfc = mfc + 16'd1;
          end else begin
            mv = mv + 10'd1;
          end
        end else begin
          mh = mh + 10'd1;
        end
      end
      mp = !mp;
    end
    e.h = mh; e.v = mv; e.vb = (mv >= 10'd480); e.fc = mfc; e.ck = mp;
    sb_q.push_back(e);
  end

  // Monitor: compares every clock's outputs against the queued prediction.
  initial forever begin
    obs_t a, x;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      a.h = if1.hcount; a.v = if1.vcount; a.vb = if1.vblank; a.fs = if1.frame_start;
      a.fc = if1.frame_count; a.ck = if1.VGA_CLK;
      a.rgb1 = {if1.VGA_R, if1.VGA_G, if1.VGA_B};
      a.hs1 = if1.VGA_HS; a.vs1 = if1.VGA_VS; a.bn1 = if1.VGA_BLANK_n;
      a.rgb3 = {if3.VGA_R, if3.VGA_G, if3.VGA_B};
      a.hs3 = if3.VGA_HS; a.vs3 = if3.VGA_VS; a.bn3 = if3.VGA_BLANK_n;
      n_vec++;
      if (a !== x) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got h=%0d v=%0d vb=%b fs=%b fc=%h ck=%b p1=%h/%b%b%b p3=%h/%b%b%b, expected h=%0d v=%0d vb=%b fs=%b fc=%h ck=%b p1=%h/%b%b%b p3=%h/%b%b%b",
                 $time, a.h, a.v, a.vb, a.fs, a.fc, a.ck, a.rgb1, a.hs1, a.vs1, a.bn1, a.rgb3, a.hs3, a.vs3, a.bn3,
                 x.h, x.v, x.vb, x.fs, x.fc, x.ck, x.rgb1, x.hs1, x.vs1, x.bn1, x.rgb3, x.hs3, x.vs3, x.bn3);
      end
    end
  end

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic chk_idle(input string name);
    check(name,
          96'({if1.hcount, if1.vcount, if1.frame_count, if1.frame_start, if1.VGA_HS, if1.VGA_VS,
               if1.VGA_BLANK_n, if1.VGA_SYNC_n, if1.VGA_CLK, if1.VGA_R, if1.VGA_G, if1.VGA_B,
               if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_HS, if3.VGA_VS, if3.VGA_BLANK_n}),
          96'({10'd0, 10'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0}));
  endtask

  task automatic wait_counts(input logic [9:0] h, input logic [9:0] v);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (if1.hcount == h && if1.vcount == v) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_counts: got h=%0d v=%0d, required h=%0d v=%0d", if1.hcount, if1.vcount, h, v);
  endtask

  task automatic force_state(input logic [9:0] h, input logic [9:0] v, input logic [15:0] fc);
    @(negedge clk);
    #2;
    jh = h; jv = v; jfc = fc;
    force dut1.u_cnt.hcount_q      = jh;
    force dut1.u_cnt.vcount_q      = jv;
    force dut1.u_cnt.frame_count_q = jfc;
    force dut3.u_cnt.hcount_q      = jh;
    force dut3.u_cnt.vcount_q      = jv;
    force dut3.u_cnt.frame_count_q = jfc;
    jump_seq++;
    #1;
    release dut1.u_cnt.hcount_q;
    release dut1.u_cnt.vcount_q;
    release dut1.u_cnt.frame_count_q;
    release dut3.u_cnt.hcount_q;
    release dut3.u_cnt.vcount_q;
    release dut3.u_cnt.frame_count_q;
  endtask

  initial begin
    int  cnt_low, first_h, first_v, fs_seen;
    bit  seen799;

    // Reset state, then first tick on the 2nd edge after release
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("edge1_no_tick", 96'({if1.VGA_CLK, if1.hcount}), 96'({1'b1, 10'd0}));
    @(negedge clk);
    check("edge2_tick", 96'({if1.VGA_CLK, if1.hcount}), 96'({1'b0, 10'd1}));

    // One full line: HS low for 96 ticks, starting with pins for count 656
    cnt_low = 0; first_h = -1; seen799 = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!if1.VGA_CLK && !if1.VGA_HS) begin
        if (cnt_low == 0) first_h = int'(if1.hcount);
        cnt_low++;
      end
      if (if1.hcount == 10'd799) seen799 = 1'b1;
      if (if1.hcount == 10'd2 && if1.vcount == 10'd1) break;
    end
    check("hs_low_ticks", 96'(cnt_low), 96'd96);
    check("hs_first_h", 96'(first_h), 96'd657);
    check("line_wrap", 96'({seen799, if1.vcount, if1.hcount}), 96'({1'b1, 10'd1, 10'd2}));

    // Pixel alignment on line 7 for both pipeline depths
    force_state(10'd0, 10'd7, 16'd0);
    wait_counts(10'd6, 10'd7);
    check("p1_pix_5_7", 96'({if1.VGA_R, if1.VGA_G, if1.VGA_B, if1.VGA_BLANK_n}), 96'({24'h0507A5, 1'b1}));
    wait_counts(10'd8, 10'd7);
    check("p3_pix_5_7", 96'({if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_BLANK_n}), 96'({24'h0507A5, 1'b1}));
    wait_counts(10'd641, 10'd7);
    check("p1_blank_640", 96'({if1.VGA_R, if1.VGA_G, if1.VGA_B, if1.VGA_BLANK_n}), 96'({24'h0, 1'b0}));
    wait_counts(10'd642, 10'd7);
    check("p3_last_639", 96'({if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_BLANK_n}), 96'({24'h7F07A5, 1'b1}));
    wait_counts(10'd643, 10'd7);
    check("p3_blank_640", 96'({if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_BLANK_n}), 96'({24'h0, 1'b0}));
    wait_counts(10'd2, 10'd8);
    check("p3_pre_first", 96'({if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_BLANK_n}), 96'({24'h0, 1'b0}));
    wait_counts(10'd3, 10'd8);
    check("p3_first_0_8", 96'({if3.VGA_R, if3.VGA_G, if3.VGA_B, if3.VGA_BLANK_n}), 96'({24'h0008A5, 1'b1}));

    // Vertical sync: lines 490-491 only
    force_state(10'd790, 10'd489, 16'd0);
    cnt_low = 0; first_h = -1; first_v = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!if1.VGA_CLK && !if1.VGA_VS) begin
        if (cnt_low == 0) begin
          first_h = int'(if1.hcount);
          first_v = int'(if1.vcount);
        end
        cnt_low++;
      end
      if (if1.hcount == 10'd20 && if1.vcount == 10'd492) break;
    end
    check("vs_low_ticks", 96'(cnt_low), 96'd1600);
    check("vs_first_pos", 96'({first_v[9:0], first_h[9:0]}), 96'({10'd490, 10'd1}));
    check("vblank_492", 96'({if1.vblank, if1.vcount}), 96'({1'b1, 10'd492}));

    // Frame wrap with frame_count at FFFF
    force_state(10'd796, 10'd524, 16'hFFFF);
    @(negedge clk);
    check("vblank_524", 96'({if1.vblank, if1.vcount, if1.frame_count}), 96'({1'b1, 10'd524, 16'hFFFF}));
    fs_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if1.frame_start) begin
        fs_seen++;
        check("fs_at_origin", 96'({if1.hcount, if1.vcount, if1.frame_count, if1.vblank}),
              96'({10'd0, 10'd0, 16'h0000, 1'b0}));
      end
    end
    check("fs_pulse_count", 96'(fs_seen), 96'd1);
    check("fc_wrapped", 96'(if1.frame_count), 96'd0);

    // Mid-frame reset at (300,200)
    force_state(10'd298, 10'd200, 16'h0005);
    wait_counts(10'd300, 10'd200);
    #2 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_idle("mid_reset");
    end
    #2 reset = 1'b1;
    fs_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if1.frame_start) fs_seen++;
      if (k == 1) check("restart_first_tick", 96'({if1.vcount, if1.hcount}), 96'({10'd0, 10'd1}));
    end
    check("no_fs_after_reset", 96'(fs_seen), 96'd0);
    check("fc_after_reset", 96'(if1.frame_count), 96'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
